// File: rtl/usb_rx_sequencer.sv
// Full-speed USB receive sequencer: gates the clock-recovery DPLL, finds SYNC,
// NRZI-decodes and unstuffs the bit stream, and flags EOP or abort causes.
module usb_rx_sequencer #(
  parameter int SYNC_TIMEOUT_BITS = 16,
  parameter int IDLE_J_CYCLES     = 8
) (
  input  logic       clk48,
  input  logic       RST,
  input  logic       dpSync,
  input  logic       dnSync,
  input  logic       readCLK12,
  output logic       dpllRst,
  output logic       rxActive,
  output logic       dataValid,
  output logic       dataBit,
  output logic       eop,
  output logic       rxError,
  output logic [1:0] errCode
);
  localparam int TW = $clog2(SYNC_TIMEOUT_BITS + 1);
  localparam int JW = $clog2(IDLE_J_CYCLES + 1);
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_SE1 = 2'b11;
  // History holds 1 for K, oldest symbol in the MSB: K J K J K J K K.
  localparam logic [7:0]    SYNC_PAT = 8'b1010_1011;
  localparam logic [TW-1:0] TMO_MAX  = TW'(SYNC_TIMEOUT_BITS);
  localparam logic [JW-1:0] J_MAX    = JW'(IDLE_J_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP1, S_EOP2, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic          clk12_q;
  logic [7:0]    hist_q, hist_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [JW-1:0] jcnt_q, jcnt_d;
  logic [2:0]    ones_q, ones_d;
  logic          ref_k_q, ref_k_d;
  logic          dpllRst_q, rxActive_q, dv_q, bit_q, eop_q, err_q;
  logic          dv_d, bit_d, eop_d, err_d;
  logic [1:0]    code_q, code_d;

  logic [1:0]    line;
  logic          sample, line_k, raw;
  logic [7:0]    hist_nx;
  logic [TW-1:0] tmo_inc;
  logic [JW-1:0] jcnt_inc;

  assign line     = {dpSync, dnSync};
  assign sample   = readCLK12 & ~clk12_q;
  assign line_k   = (line == LS_K);
  assign raw      = (line_k == ref_k_q);
  assign hist_nx  = {hist_q[6:0], line_k};
  assign tmo_inc  = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
  assign jcnt_inc = (jcnt_q == J_MAX) ? jcnt_q : jcnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    tmo_d   = tmo_q;
    jcnt_d  = jcnt_q;
    ones_d  = ones_q;
    ref_k_d = ref_k_q;
    dv_d    = 1'b0;
    bit_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    code_d  = 2'd0;
    unique case (state_q)
      S_IDLE: if (line == LS_K) begin
        state_d = S_SYNC;
        hist_d  = '0;
        tmo_d   = '0;
      end
      S_SYNC: if (sample) begin
        if (line == LS_SE0 || line == LS_SE1) begin
          err_d  = 1'b1;
          code_d = 2'd3;
        end else begin
          hist_d = hist_nx;
          tmo_d  = tmo_inc;
          if (hist_nx == SYNC_PAT) begin
            state_d = S_DATA;
            ref_k_d = 1'b1;
            ones_d  = '0;
          end else if (tmo_inc == TMO_MAX) begin
            err_d  = 1'b1;
            code_d = 2'd1;
          end
        end
      end
      S_DATA: if (sample) begin
        if (line == LS_SE0) begin
          state_d = S_EOP1;
        end else if (line == LS_SE1) begin
          err_d  = 1'b1;
          code_d = 2'd3;
        end else begin
          ref_k_d = line_k;
          if (raw) begin
            if (ones_q == 3'd6) begin
              err_d  = 1'b1;
              code_d = 2'd2;
            end else begin
              dv_d   = 1'b1;
              bit_d  = 1'b1;
              ones_d = ones_q + 3'd1;
            end
          end else begin
            // A zero after six ones is the stuffed bit and is dropped.
            dv_d   = (ones_q != 3'd6);
            ones_d = '0;
          end
        end
      end
      S_EOP1: if (sample) begin
        if (line == LS_SE0) state_d = S_EOP2;
        else begin
          err_d  = 1'b1;
          code_d = 2'd3;
        end
      end
      S_EOP2: if (sample) begin
        if (line == LS_J) begin
          eop_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          err_d  = 1'b1;
          code_d = 2'd3;
        end
      end
      S_WAIT: begin
        if (line == LS_J) begin
          jcnt_d = jcnt_inc;
          if (jcnt_inc == J_MAX) state_d = S_IDLE;
        end else begin
          jcnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (err_d) begin
      state_d = S_WAIT;
      jcnt_d  = '0;
    end
  end

  always_ff @(posedge clk48) begin
    if (RST) begin
      state_q    <= S_IDLE;
      clk12_q    <= 1'b0;
      hist_q     <= '0;
      tmo_q      <= '0;
      jcnt_q     <= '0;
      ones_q     <= '0;
      ref_k_q    <= 1'b1;
      dpllRst_q  <= 1'b1;
      rxActive_q <= 1'b0;
      dv_q       <= 1'b0;
      bit_q      <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      clk12_q    <= readCLK12;
      hist_q     <= hist_d;
      tmo_q      <= tmo_d;
      jcnt_q     <= jcnt_d;
      ones_q     <= ones_d;
      ref_k_q    <= ref_k_d;
      dpllRst_q  <= (state_d == S_IDLE) || (state_d == S_WAIT);
      rxActive_q <= (state_d == S_DATA) || (state_d == S_EOP1) || (state_d == S_EOP2);
      dv_q       <= dv_d;
      bit_q      <= bit_d;
      eop_q      <= eop_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign dpllRst   = dpllRst_q;
  assign rxActive  = rxActive_q;
  assign dataValid = dv_q;
  assign dataBit   = bit_q;
  assign eop       = eop_q;
  assign rxError   = err_q;
  assign errCode   = code_q;
endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Bench for usb_rx_sequencer: packets are built from payload bits by an NRZI/stuffing
// encoder that also records the strobes and pulses each line symbol should produce.
module tb_usb_rx_sequencer;
  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00, LSE1 = 2'b11;
  localparam int EV_NONE = 0, EV_DV = 1, EV_EOP = 2, EV_ERR = 3, EV_SYNC = 4;
  localparam int TMO = 16;

  logic       clk48 = 1'b0;
  logic       RST = 1'b1, dpSync = 1'b1, dnSync = 1'b0, readCLK12 = 1'b0;
  logic       dpllRst, rxActive, dataValid, dataBit, eop, rxError;
  logic [1:0] errCode;
  int         checks = 0, failures = 0;

  usb_rx_sequencer #(.SYNC_TIMEOUT_BITS(TMO), .IDLE_J_CYCLES(8)) dut (
    .clk48(clk48), .RST(RST), .dpSync(dpSync), .dnSync(dnSync), .readCLK12(readCLK12),
    .dpllRst(dpllRst), .rxActive(rxActive), .dataValid(dataValid), .dataBit(dataBit),
    .eop(eop), .rxError(rxError), .errCode(errCode)
  );

  always #10 clk48 = ~clk48;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected-behaviour queues, one entry per line symbol (bit period).
  logic [1:0] q_sym[$];
  int         q_ev[$];
  bit         q_bit[$];
  logic [1:0] q_code[$];
  bit         pay[$];

  task automatic push(input logic [1:0] s, input int ev, input bit b, input logic [1:0] code);
    q_sym.push_back(s); q_ev.push_back(ev); q_bit.push_back(b); q_code.push_back(code);
  endtask

  task automatic add_sync();
    for (int i = 0; i < 8; i++)
      push((i % 2 == 0 || i == 7) ? LK : LJ, (i == 7) ? EV_SYNC : EV_NONE, 1'b0, 2'd0);
  endtask

  // NRZI: 1 keeps the line, 0 toggles it. Without stuffing, a seventh 1 aborts and
  // a genuine 0 after six 1s is indistinguishable from a stuffed bit, so it vanishes.
  task automatic add_data(input bit stuff_en, output bit aborted);
    logic [1:0] r = LK;
    int ones = 0;
    aborted = 1'b0;
    foreach (pay[i]) begin
      if (pay[i]) begin
        if (ones == 6) begin
          push(r, EV_ERR, 1'b0, 2'd2);
          aborted = 1'b1;
          return;
        end
        push(r, EV_DV, 1'b1, 2'd0);
        ones++;
      end else begin
        r = (r == LK) ? LJ : LK;
        push(r, (ones == 6) ? EV_NONE : EV_DV, 1'b0, 2'd0);
        ones = 0;
      end
      if (stuff_en && ones == 6) begin
        r = (r == LK) ? LJ : LK;
        push(r, EV_NONE, 1'b0, 2'd0);
        ones = 0;
      end
    end
  endtask

  task automatic add_eop();
    push(LSE0, EV_NONE, 1'b0, 2'd0);
    push(LSE0, EV_NONE, 1'b0, 2'd0);
    push(LJ, EV_EOP, 1'b0, 2'd0);
  endtask

  // J/K stream with no KK pair can never complete SYNC, so it must time out.
  task automatic add_nosync(input int n, input bit rnd);
    logic [1:0] s, prev;
    prev = LJ;
    for (int i = 1; i <= n; i++) begin
      if (i == 1) s = LK;
      else if (prev == LK) s = LJ;
      else if (rnd) s = ($urandom_range(0, 1) != 0) ? LK : LJ;
      else s = LK;
      prev = s;
      if (i == TMO) begin
        push(s, EV_ERR, 1'b0, 2'd1);
        return;
      end
      push(s, EV_NONE, 1'b0, 2'd0);
    end
  endtask

  task automatic byte_pay(input logic [7:0] b);
    pay.delete();
    for (int i = 0; i < 8; i++) pay.push_back(b[i]);
  endtask

  task automatic gen_pay(input int nbits);
    pay.delete();
    for (int i = 0; i < nbits; i++) pay.push_back($urandom_range(0, 3) != 0);
  endtask

  // One bit period = 4 clk48 cycles, bit-clock rising edge in the second.
  task automatic send_sym(input logic [1:0] s, input int ev, input bit b,
                          input logic [1:0] code, input bit first);
    for (int c = 0; c < 4; c++) begin
      {dpSync, dnSync} = s;
      readCLK12 = (c == 1);
      @(posedge clk48); @(negedge clk48);
      if (c == 1) begin
        chk("dataValid", dataValid, ev == EV_DV);
        chk("eop", eop, ev == EV_EOP);
        chk("rxError", rxError, ev == EV_ERR);
        if (ev == EV_DV) begin
          chk("dataBit", dataBit, b);
          chk("active_data", rxActive, 1);
        end
        if (ev == EV_SYNC) chk("active_sync", rxActive, 1);
        if (ev == EV_ERR) begin
          chk("errCode", errCode, code);
          chk("active_err", rxActive, 0);
          chk("dpllRst_err", dpllRst, 1);
        end
        if (ev == EV_EOP) begin
          chk("active_eop", rxActive, 0);
          chk("dpllRst_eop", dpllRst, 1);
        end
      end else begin
        chk("quiet", {dataValid, eop, rxError}, 0);
        if (first && c == 0) chk("dpll_release", dpllRst, 0);
      end
    end
  endtask

  task automatic play();
    for (int i = 0; i < q_sym.size(); i++)
      send_sym(q_sym[i], q_ev[i], q_bit[i], q_code[i], i == 0);
    q_sym.delete(); q_ev.delete(); q_bit.delete(); q_code.delete();
  endtask

  task automatic idle_j(input int n);
    for (int i = 0; i < n; i++) begin
      {dpSync, dnSync} = LJ;
      readCLK12 = (i % 4 == 1);
      @(posedge clk48); @(negedge clk48);
      chk("idle_quiet", {dataValid, eop, rxError}, 0);
      chk("idle_dpllRst", dpllRst, 1);
      chk("idle_active", rxActive, 0);
    end
  endtask

  task automatic kpoke();
    {dpSync, dnSync} = LK;
    readCLK12 = 1'b1;
    @(posedge clk48); @(negedge clk48);
    chk("wait_k_dpllRst", dpllRst, 1);
    chk("wait_k_quiet", {dataValid, eop, rxError}, 0);
  endtask

  initial begin : main
    bit ab;
    int nb, tail;
    bit se;
    repeat (3) @(negedge clk48);
    chk("rst_dpllRst", dpllRst, 1);
    chk("rst_rxActive", rxActive, 0);
    chk("rst_dataValid", dataValid, 0);
    chk("rst_dataBit", dataBit, 0);
    chk("rst_eop", eop, 0);
    chk("rst_rxError", rxError, 0);
    chk("rst_errCode", errCode, 0);
    RST = 1'b0;
    idle_j(8);

    add_sync(); byte_pay(8'hA5); add_data(1'b1, ab); add_eop(); play();
    idle_j(4);
    add_sync(); byte_pay(8'hFF); add_data(1'b1, ab); add_eop(); play();
    idle_j(4);
    add_sync(); byte_pay(8'hFF); add_data(1'b0, ab); play();
    idle_j(5); kpoke(); idle_j(7); kpoke(); idle_j(8);

    add_nosync(TMO + 1, 1'b0); play(); idle_j(12);
    add_nosync(TMO + 1, 1'b1); play(); idle_j(12);
    push(LK, EV_NONE, 1'b0, 2'd0); push(LJ, EV_NONE, 1'b0, 2'd0);
    push(LSE0, EV_ERR, 1'b0, 2'd3); play(); idle_j(8);

    add_sync(); gen_pay(5); add_data(1'b1, ab);
    push(LSE0, EV_NONE, 1'b0, 2'd0); push(LJ, EV_ERR, 1'b0, 2'd3); play(); idle_j(8);
    add_sync(); gen_pay(4); add_data(1'b1, ab);
    push(LSE1, EV_ERR, 1'b0, 2'd3); play(); idle_j(8);

    add_sync(); gen_pay(3); add_data(1'b1, ab); play();
    RST = 1'b1; {dpSync, dnSync} = LJ; readCLK12 = 1'b0;
    @(posedge clk48); @(negedge clk48);
    chk("midrst_dpllRst", dpllRst, 1);
    chk("midrst_rxActive", rxActive, 0);
    chk("midrst_quiet", {dataValid, eop, rxError}, 0);
    RST = 1'b0;
    idle_j(3);
    add_sync(); byte_pay(8'(($urandom_range(0, 255)))); add_data(1'b1, ab); add_eop(); play();
    idle_j(3);

    for (int it = 0; it < 30; it++) begin
      nb   = $urandom_range(1, 24);
      tail = $urandom_range(0, 7);
      se   = ($urandom_range(0, 3) != 0);
      gen_pay(nb); add_sync(); add_data(se, ab);
      if (!ab) begin
        if (tail == 0) begin
          push(LSE1, EV_ERR, 1'b0, 2'd3); ab = 1'b1;
        end else if (tail == 1) begin
          push(LSE0, EV_NONE, 1'b0, 2'd0); push(LK, EV_ERR, 1'b0, 2'd3); ab = 1'b1;
        end else begin
          add_eop();
        end
      end
      play();
      idle_j(ab ? $urandom_range(8, 12) : $urandom_range(1, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_rx_sequencer.md
# usb_rx_sequencer

Receive-side controller for the full-speed USB front end. It sequences the 48 MHz clock-recovery DPLL: it holds the DPLL in reset while the bus idles and releases it on the first K of a packet. It samples the line on every recovered 12 MHz bit edge, then detects SYNC, NRZI-decodes, removes stuffed bits and detects EOP. Its outputs are a per-bit data strobe and packet framing/error pulses for the downstream packet decoder.

## Interface
- SYNC_TIMEOUT_BITS, 16: bit samples allowed after DPLL release without a SYNC match before aborting.
- IDLE_J_CYCLES, 8: consecutive clk48 cycles of J needed to re-arm after an error.

- clk48  in  1  48 MHz system clock.
- RST  in  1  reset: synchronous, active-high.
- dpSync  in  1  D+ already synchronized to clk48.
- dnSync  in  1  D− already synchronized to clk48.
- readCLK12  in  1  recovered bit clock from the DPLL.
- dpllRst  out  1  synchronous reset to the DPLL.
- rxActive  out  1  high while a packet is between SYNC and EOP.
- dataValid  out  1  one-cycle strobe per decoded, unstuffed bit.
- dataBit  out  1  decoded bit, valid with dataValid.
- eop  out  1  one-cycle pulse on a valid EOP.
- rxError  out  1  one-cycle pulse on abort.
- errCode  out  2  cause, valid with rxError: 1 SYNC timeout, 2 stuff error, 3 line-state error.

## Operation
- Line states are decoded from {dpSync,dnSync}:
  - J = 10
  - K = 01
  - SE0 = 00
  - SE1 = 11
- A sample event occurs in the cycle where readCLK12 = 1 and its registered previous value = 0. The line state is taken from the same cycle's inputs.
- IDLE: dpllRst = 1. The first cycle with line = K moves the FSM to SYNC, and dpllRst deasserts on the next cycle.
- SYNC: dpllRst = 0.
  - Sampled symbols shift into an 8-entry history.
  - A match on K J K J K J K K (oldest first) moves the FSM to DATA and sets rxActive.
  - The NRZI reference symbol is initialised to K and the ones-counter to 0.
  - If SYNC_TIMEOUT_BITS samples pass without a match, or an SE0/SE1 is sampled, the block raises rxError and moves to WAIT_IDLE. The code is 1 for the timeout and 3 for SE0/SE1.
- DATA: on each J/K sample the raw bit is 1 if the symbol equals the reference and 0 otherwise. The reference then takes the symbol.
  - Raw 1 with ones-counter < 6: emit the bit and increment the counter.
  - Raw 1 with ones-counter = 6: rxError with code 2, go to WAIT_IDLE.
  - Raw 0 with ones-counter = 6: stuffed bit. Drop it (no dataValid) and clear the counter.
  - Any other raw 0: emit 0 and clear the counter.
  - SE0 goes to EOP1. SE1 gives rxError with code 3 and goes to WAIT_IDLE.
- EOP1: the next sample must be SE0, which goes to EOP2. Anything else gives error code 3.
- EOP2: the next sample must be J. On J the block pulses eop, clears rxActive, sets dpllRst and goes to IDLE. Anything else gives error code 3.
- WAIT_IDLE: dpllRst = 1 and rxActive = 0. The FSM returns to IDLE after IDLE_J_CYCLES consecutive clk48 cycles of line = J; any non-J cycle restarts the count.
- Every error path clears rxActive in the same cycle as the rxError pulse.
- The SYNC timeout counter and the J counter are sized by $clog2 of their parameter + 1 and saturate rather than wrap.

## Timing
- Reset values:
  - dpllRst = 1
  - rxActive = 0
  - dataValid = 0
  - dataBit = 0
  - eop = 0
  - rxError = 0
  - errCode = 0
  - FSM = IDLE
- RST dominates all other events, including mid-packet. No eop or rxError is emitted for a packet aborted by RST.
- All outputs are registered.
- dataValid/dataBit, eop and rxError assert exactly one clk48 cycle after the sample event that causes them.
- The K→dpllRst release latency is 1 cycle: the K is seen in cycle n and dpllRst = 0 in cycle n+1.
- At most one dataValid is produced per sample event. dataValid, eop and rxError are never high together.
- A sample event arriving in IDLE or WAIT_IDLE is ignored.

## Test plan
- Clean packet: 8 idle J cycles, then SYNC followed by data byte 0xA5 (LSB first, NRZI-encoded, no stuffing), then SE0 SE0 J at 4 clk48/bit → exactly 8 dataValid strobes with bits 1,0,1,0,0,1,0,1, then eop, with dpllRst high again on the eop cycle.
- Bit stuffing: payload 0xFF plus a stuffed 0 → 8 strobes, all 1s, with the stuffed bit dropped. The same stream without the stuffed 0 → rxError with errCode 2 on the 7th consecutive 1, then no strobes until 8 J cycles have passed.
- SYNC timeout: a K followed by 16 alternating J/K samples that never end in KK → rxError with errCode 1 exactly once; dpllRst = 1 in the next cycle.
- Bad EOP: a single SE0 followed by J → rxError with errCode 3 and no eop pulse.
- SE1 mid-data → rxError with errCode 3 and rxActive dropping in the same cycle.
- Reset mid-packet: RST asserted after 3 data bits → next cycle shows dpllRst = 1 and rxActive = 0 with no pulses. A fresh packet afterwards decodes correctly.
